// File: rtl/spr_dma.sv
// Sprite OAM DMA engine: a CPU write to TRIG_ADDR latches a source page, then the
// engine owns the bus and copies {page,00}..{page,FF} to DST_ADDR, one byte per 3 cycles.
module spr_dma #(
  parameter logic [15:0] TRIG_ADDR = 16'h4014,
  parameter logic [15:0] DST_ADDR  = 16'h2004
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [15:0] cpu_a,
  input  logic        cpu_r_nw,
  input  logic [7:0]  cpu_dout,
  input  logic [7:0]  mem_din,
  input  logic        halt,
  output logic        active,
  output logic [15:0] a,
  output logic        r_nw,
  output logic [7:0]  dout,
  output logic        done
);

  typedef enum logic [1:0] {S_IDLE, S_READ, S_WAIT, S_WRITE} state_t;

  state_t      r_state;
  logic        r_armed;
  logic        r_halted;
  logic        r_active;
  logic        r_r_nw;
  logic        r_done;
  logic [7:0]  r_cnt;
  logic [7:0]  r_page;
  logic [7:0]  r_data;
  logic [15:0] r_a;

  logic        w_match;
  logic [7:0]  w_cnt_nxt;

  assign w_match   = (cpu_a == TRIG_ADDR) && !cpu_r_nw && !halt;
  assign w_cnt_nxt = r_cnt + 8'd1;

  assign active = r_active;
  assign a      = r_a;
  assign r_nw   = r_r_nw;
  assign dout   = r_data;
  assign done   = r_done;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state  <= S_IDLE;
      r_armed  <= 1'b1;
      r_halted <= 1'b0;
      r_active <= 1'b0;
      r_a      <= 16'h0000;
      r_r_nw   <= 1'b1;
      r_done   <= 1'b0;
      r_cnt    <= 8'h00;
      r_page   <= 8'h00;
      r_data   <= 8'h00;
    end else begin
      // Re-arm only after a cycle without a match, so a held CPU write fires once.
      r_armed <= !w_match;
      r_done  <= 1'b0;
      if (r_state == S_IDLE) begin
        if (w_match && r_armed) begin
          r_page   <= cpu_dout;
          r_cnt    <= 8'h00;
          r_state  <= S_READ;
          r_active <= 1'b1;
          r_a      <= {cpu_dout, 8'h00};
          r_r_nw   <= 1'b1;
        end
      end else if (halt) begin
        r_halted <= 1'b1;
        r_r_nw   <= 1'b1;
      end else if (r_halted) begin
        // The debugger may have disturbed the RAM pipeline: redo the current byte.
        r_halted <= 1'b0;
        r_state  <= S_READ;
        r_a      <= {r_page, r_cnt};
        r_r_nw   <= 1'b1;
      end else begin
        case (r_state)
          S_READ: r_state <= S_WAIT;
          S_WAIT: begin
            r_data  <= mem_din;
            r_a     <= DST_ADDR;
            r_r_nw  <= 1'b0;
            r_state <= S_WRITE;
          end
          S_WRITE: begin
            r_cnt  <= w_cnt_nxt;
            r_r_nw <= 1'b1;
            if (r_cnt == 8'hFF) begin
              r_state  <= S_IDLE;
              r_active <= 1'b0;
              r_a      <= 16'h0000;
              r_data   <= 8'h00;
              r_done   <= 1'b1;
            end else begin
              r_state <= S_READ;
              r_a     <= {r_page, w_cnt_nxt};
            end
          end
          default: ;
        endcase
      end
    end
  end

endmodule
